// File: rtl/lebug_acc_pkg.sv
// Shared definitions for the frame accumulator: firmware accumulation modes
// and, when ACCUM_SATURATE_EN is defined, the saturating lane adder.
package lebug_acc_pkg;

   // Firmware accumulation modes; any other 8-bit value behaves as ACC_PASS.
   typedef enum logic [7:0] {
      ACC_PASS    = 8'd0,
      ACC_FRAME   = 8'd1,
      ACC_RUNNING = 8'd2
   } acc_mode_e;

`ifdef ACCUM_SATURATE_EN
   // Signed add of two w-bit values held sign-extended in 64 bits, clamped to
   // the w-bit signed range. Valid for w up to 63.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned w);
      logic signed [63:0] s;
      logic signed [63:0] mx;
      logic signed [63:0] mn;
      s  = a + b;
      mx = (64'sd1 <<< (w - 1)) - 64'sd1;
      mn = -mx - 64'sd1;
      if (s > mx) return mx;
      if (s < mn) return mn;
      return s;
   endfunction
`endif

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: on bof the input replaces the accumulator, otherwise
// it is added to it. Saturating add when ACCUM_SATURATE_EN is defined,
// modular wrap otherwise.
module acc_lane
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  bof_i,
   input  logic [DATA_WIDTH-1:0] acc_i,
   input  logic [DATA_WIDTH-1:0] vec_i,
   output logic [DATA_WIDTH-1:0] sum_o
);
`ifdef ACCUM_SATURATE_EN
   import lebug_acc_pkg::*;

   logic signed [63:0] sat_full;

   // Select bof restart or clamped sum.
   always_comb begin
      sat_full = sat_add(64'(signed'(acc_i)), 64'(signed'(vec_i)), DATA_WIDTH);
      sum_o    = bof_i ? vec_i : sat_full[DATA_WIDTH-1:0];
   end
`else
   // Select bof restart or wrapping sum.
   always_comb begin
      sum_o = bof_i ? vec_i : acc_i + vec_i;
   end
`endif
endmodule

// File: rtl/frame_accumulator_unit.sv
// Per-chain elementwise vector accumulator. Each chain runs in pass, frame
// (one sum per bof..eof) or running-sum mode, selected by a firmware mode
// register loaded through a shift-register config port. Outputs are
// registered, one cycle after the accepted beat. Optional build macro:
// ACCUM_SATURATE_EN (saturating lane adds instead of wrap).
module frame_accumulator_unit
   import lebug_acc_pkg::*;
#(
   parameter int                        N                         = 8,
   parameter int                        DATA_WIDTH                = 32,
   parameter int                        MAX_CHAINS                = 4,
   parameter int                        PERSONAL_CONFIG_ID        = 1,
   parameter logic [MAX_CHAINS*8-1:0]   INITIAL_FIRMWARE_ACC_MODE = '0,
   localparam int                       CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              tracing,
   input  logic                              valid_in,
   input  logic                              eof_in,
   input  logic                              bof_in,
   input  logic [CW-1:0]                     chainId_in,
   input  logic [7:0]                        configId,
   input  logic [7:0]                        configData,
   input  logic [N-1:0][DATA_WIDTH-1:0]      vector_in,
   output logic [N-1:0][DATA_WIDTH-1:0]      vector_out,
   output logic [CW-1:0]                     chainId_out,
   output logic                              valid_out,
   output logic                              eof_out,
   output logic                              bof_out
);

   logic [N-1:0][DATA_WIDTH-1:0] acc_q [MAX_CHAINS];
   logic [N-1:0][DATA_WIDTH-1:0] acc_d [MAX_CHAINS];
   logic [7:0]                   mode_q [MAX_CHAINS];
   logic [7:0]                   mode_d [MAX_CHAINS];

   logic [N-1:0][DATA_WIDTH-1:0] vector_out_q, vector_out_d;
   logic [CW-1:0]                chain_id_out_q, chain_id_out_d;
   logic                         valid_out_q, valid_out_d;
   logic                         bof_out_q, bof_out_d;
   logic                         eof_out_q, eof_out_d;

   logic [N-1:0][DATA_WIDTH-1:0] acc_new;
   logic                         accept;
   logic [7:0]                   cur_mode;

   // Next accumulator value for the addressed chain, one lane per instance.
   for (genvar g = 0; g < N; g++) begin : g_lane
      acc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .bof_i (bof_in),
         .acc_i (acc_q[chainId_in][g]),
         .vec_i (vector_in[g]),
         .sum_o (acc_new[g])
      );
   end

   assign accept   = valid_in & tracing;
   assign cur_mode = mode_q[chainId_in];

   // Beat handling per mode, then the config shift (beat sees pre-write mode).
   always_comb begin
      acc_d          = acc_q;
      mode_d         = mode_q;
      vector_out_d   = vector_out_q;
      chain_id_out_d = chain_id_out_q;
      bof_out_d      = bof_out_q;
      eof_out_d      = eof_out_q;
      valid_out_d    = 1'b0;

      if (accept) begin
         case (cur_mode)
            ACC_FRAME: begin
               if (eof_in) begin
                  acc_d[chainId_in] = '0;
                  valid_out_d       = 1'b1;
                  vector_out_d      = acc_new;
                  chain_id_out_d    = chainId_in;
                  bof_out_d         = 1'b1;
                  eof_out_d         = 1'b1;
               end else begin
                  acc_d[chainId_in] = acc_new;
               end
            end
            ACC_RUNNING: begin
               acc_d[chainId_in] = eof_in ? '0 : acc_new;
               valid_out_d       = 1'b1;
               vector_out_d      = acc_new;
               chain_id_out_d    = chainId_in;
               bof_out_d         = bof_in;
               eof_out_d         = eof_in;
            end
            default: begin
               valid_out_d    = 1'b1;
               vector_out_d   = vector_in;
               chain_id_out_d = chainId_in;
               bof_out_d      = bof_in;
               eof_out_d      = eof_in;
            end
         endcase
      end

      if (configId == 8'(PERSONAL_CONFIG_ID)) begin
         for (int i = 0; i < MAX_CHAINS - 1; i++) begin
            mode_d[i] = mode_q[i + 1];
         end
         mode_d[MAX_CHAINS-1] = configData;
      end
   end

   // State and output registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < MAX_CHAINS; c++) begin
            acc_q[c]  <= '0;
            mode_q[c] <= INITIAL_FIRMWARE_ACC_MODE[c*8 +: 8];
         end
         vector_out_q   <= '0;
         chain_id_out_q <= '0;
         valid_out_q    <= 1'b0;
         bof_out_q      <= 1'b0;
         eof_out_q      <= 1'b0;
      end else begin
         acc_q          <= acc_d;
         mode_q         <= mode_d;
         vector_out_q   <= vector_out_d;
         chain_id_out_q <= chain_id_out_d;
         valid_out_q    <= valid_out_d;
         bof_out_q      <= bof_out_d;
         eof_out_q      <= eof_out_d;
      end
   end

   assign vector_out  = vector_out_q;
   assign chainId_out = chain_id_out_q;
   assign valid_out   = valid_out_q;
   assign bof_out     = bof_out_q;
   assign eof_out     = eof_out_q;

endmodule

// File: tb/tb_frame_accumulator_unit.sv
// Bench for frame_accumulator_unit: directed table, hand sequences for config,
// overflow and mid-frame reset, then randomized traffic against a model.
module tb_frame_accumulator_unit;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int MC = 4;

   typedef logic [N-1:0][DW-1:0] vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tracing = 1'b0;
   logic       valid_in = 1'b0;
   logic       eof_in = 1'b0;
   logic       bof_in = 1'b0;
   logic [1:0] chainId_in = '0;
   logic [7:0] configId = '0;
   logic [7:0] configData = '0;
   vec_t       vector_in = '0;
   vec_t       vector_out;
   logic [1:0] chainId_out;
   logic       valid_out, eof_out, bof_out;

   int errors = 0;
   int checks = 0;

   // Reference state: per-chain sums and modes, expected registered outputs.
   logic [DW-1:0] m_acc [MC][N];
   logic [7:0]    m_mode [MC];
   logic [DW-1:0] m_vec [N];
   logic [1:0]    m_ch;
   logic          m_valid, m_bof, m_eof;

   frame_accumulator_unit dut (
      .clk(clk), .reset_n(reset_n), .tracing(tracing), .valid_in(valid_in),
      .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
      .configId(configId), .configData(configData), .vector_in(vector_in),
      .vector_out(vector_out), .chainId_out(chainId_out), .valid_out(valid_out),
      .eof_out(eof_out), .bof_out(bof_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef ACCUM_SATURATE_EN
      longint s;
      s = longint'(signed'(a)) + longint'(signed'(b));
      if (s > 64'sd2147483647) return 32'h7fff_ffff;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return s[DW-1:0];
`else
      return a + b;
`endif
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < MC; c++) begin
         m_mode[c] = 8'd0;
         for (int l = 0; l < N; l++) m_acc[c][l] = '0;
      end
      for (int l = 0; l < N; l++) m_vec[l] = '0;
      m_ch = '0; m_valid = 1'b0; m_bof = 1'b0; m_eof = 1'b0;
   endfunction

   // Apply one clock of the behavioural rules to the reference state.
   function automatic void model_update(input logic trc, input logic vld, input logic bof,
                                        input logic eof, input logic [1:0] ch, input vec_t vin,
                                        input logic [7:0] cid, input logic [7:0] cdat);
      logic [DW-1:0] nw [N];
      logic [7:0]    md;
      md      = m_mode[ch];
      m_valid = 1'b0;
      if (vld && trc) begin
         for (int l = 0; l < N; l++) nw[l] = bof ? vin[l] : m_add(m_acc[ch][l], vin[l]);
         if (md == 8'd1 || md == 8'd2) begin
            for (int l = 0; l < N; l++) m_acc[ch][l] = eof ? '0 : nw[l];
            if (md == 8'd2 || eof) begin
               for (int l = 0; l < N; l++) m_vec[l] = nw[l];
               m_valid = 1'b1;
               m_ch    = ch;
               m_bof   = (md == 8'd1) ? 1'b1 : bof;
               m_eof   = (md == 8'd1) ? 1'b1 : eof;
            end
         end else begin
            for (int l = 0; l < N; l++) m_vec[l] = vin[l];
            m_valid = 1'b1; m_ch = ch; m_bof = bof; m_eof = eof;
         end
      end
      if (cid == 8'd1) begin
         for (int c = 0; c < MC - 1; c++) m_mode[c] = m_mode[c + 1];
         m_mode[MC-1] = cdat;
      end
   endfunction

   task automatic compare_model(input string tag);
      vec_t ev;
      for (int l = 0; l < N; l++) ev[l] = m_vec[l];
      check({tag, ".vector"}, vector_out, ev);
      check({tag, ".valid"}, N*DW'(valid_out), N*DW'(m_valid));
      check({tag, ".chain"}, N*DW'(chainId_out), N*DW'(m_ch));
      check({tag, ".bof"}, N*DW'(bof_out), N*DW'(m_bof));
      check({tag, ".eof"}, N*DW'(eof_out), N*DW'(m_eof));
   endtask

   // Drive one cycle (called #1 after a rising edge), then compare after the edge.
   task automatic step(input logic trc, input logic vld, input logic bof, input logic eof,
                       input logic [1:0] ch, input vec_t vin,
                       input logic [7:0] cid, input logic [7:0] cdat);
      tracing = trc; valid_in = vld; bof_in = bof; eof_in = eof;
      chainId_in = ch; vector_in = vin; configId = cid; configData = cdat;
      @(posedge clk);
      model_update(trc, vld, bof, eof, ch, vin, cid, cdat);
      #1;
      compare_model("model");
   endtask

   task automatic cfg(input logic [7:0] cid, input logic [7:0] d);
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0, cid, d);
   endtask

   task automatic beat(input logic bof, input logic eof, input logic [1:0] ch, input logic [DW-1:0] lane);
      step(1'b1, 1'b1, bof, eof, ch, {N{lane}}, 8'd0, 8'd0);
   endtask

   // Hand-derived expectation on the current outputs.
   task automatic expect_out(input string name, input logic ev, input logic [DW-1:0] el,
                             input logic [1:0] ec, input logic eb, input logic ee);
      check({name, ".valid"}, N*DW'(valid_out), N*DW'(ev));
      if (ev) begin
         check({name, ".vector"}, vector_out, {N{el}});
         check({name, ".chain"}, N*DW'(chainId_out), N*DW'(ec));
         check({name, ".flags"}, N*DW'({bof_out, eof_out}), N*DW'({eb, ee}));
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0; tracing = 1'b0; valid_in = 1'b0; bof_in = 1'b0; eof_in = 1'b0;
      configId = '0; configData = '0; vector_in = '0;
      #2;
      model_reset();
      check("reset.outputs_zero", {vector_out, chainId_out, valid_out, bof_out, eof_out}
            >> (N*DW + 5 - N*DW), '0);
      check("reset.vector_zero", vector_out, '0);
      compare_model("reset");
      @(posedge clk);
      #1;
      compare_model("reset_hold");
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic          trc, vld, bof, eof;
      logic [1:0]    ch;
      logic [DW-1:0] lane;
      logic          exp_valid;
      logic [DW-1:0] exp_lane;
      logic [1:0]    exp_ch;
      logic          exp_bof, exp_eof;
   } row_t;

   row_t rows [17];

   initial begin
      // Modes after config 1,2,1,0: chain0=frame, chain1=running, chain2=frame, chain3=pass.
      rows[0]  = '{1, 1, 1, 0, 0, 1,  0, 0,  0, 0, 0};
      rows[1]  = '{1, 1, 0, 0, 0, 2,  0, 0,  0, 0, 0};
      rows[2]  = '{1, 1, 0, 1, 0, 3,  1, 6,  0, 1, 1};
      rows[3]  = '{1, 1, 0, 1, 0, 4,  1, 4,  0, 1, 1};
      rows[4]  = '{1, 1, 1, 0, 1, 5,  1, 5,  1, 1, 0};
      rows[5]  = '{1, 1, 0, 0, 1, 5,  1, 10, 1, 0, 0};
      rows[6]  = '{1, 1, 0, 1, 1, 5,  1, 15, 1, 0, 1};
      rows[7]  = '{1, 1, 0, 0, 1, 7,  1, 7,  1, 0, 0};
      rows[8]  = '{1, 1, 0, 1, 1, 0,  1, 7,  1, 0, 1};
      rows[9]  = '{1, 1, 1, 0, 0, 3,  0, 0,  0, 0, 0};
      rows[10] = '{1, 1, 1, 0, 2, 10, 0, 0,  0, 0, 0};
      rows[11] = '{1, 1, 0, 0, 0, 4,  0, 0,  0, 0, 0};
      rows[12] = '{1, 1, 0, 1, 2, 20, 1, 30, 2, 1, 1};
      rows[13] = '{1, 1, 0, 1, 0, 1,  1, 8,  0, 1, 1};
      rows[14] = '{1, 1, 1, 1, 3, 9,  1, 9,  3, 1, 1};
      rows[15] = '{0, 1, 1, 1, 0, 99, 0, 9,  3, 1, 1};
      rows[16] = '{1, 1, 1, 1, 0, 5,  1, 5,  0, 1, 1};

      model_reset();
      #1;
      do_reset();

      // Config 2,1,0,1 -> chain0..3 = running, frame, pass, frame.
      cfg(8'd1, 8'd2); cfg(8'd1, 8'd1); cfg(8'd1, 8'd0); cfg(8'd1, 8'd1);
      beat(1'b1, 1'b0, 2'd2, 32'd7);
      expect_out("cfg_a.chain2_pass", 1'b1, 32'd7, 2'd2, 1'b1, 1'b0);
      beat(1'b1, 1'b0, 2'd1, 32'd3);
      expect_out("cfg_a.chain1_frame_hold", 1'b0, '0, 2'd0, 1'b0, 1'b0);
      // Writes addressed elsewhere leave every mode unchanged.
      for (int i = 0; i < MC; i++) cfg(8'd5, 8'd9);
      beat(1'b1, 1'b0, 2'd2, 32'd8);
      expect_out("cfg_b.chain2_still_pass", 1'b1, 32'd8, 2'd2, 1'b1, 1'b0);
      beat(1'b0, 1'b1, 2'd1, 32'd2);
      expect_out("cfg_b.chain1_still_frame", 1'b1, 32'd5, 2'd1, 1'b1, 1'b1);

      // Config 1,2,1,0 for the directed table.
      cfg(8'd1, 8'd1); cfg(8'd1, 8'd2); cfg(8'd1, 8'd1); cfg(8'd1, 8'd0);
      for (int r = 0; r < 17; r++) begin
         step(rows[r].trc, rows[r].vld, rows[r].bof, rows[r].eof, rows[r].ch,
              {N{rows[r].lane}}, 8'd0, 8'd0);
         check($sformatf("row%0d.valid", r), N*DW'(valid_out), N*DW'(rows[r].exp_valid));
         if (rows[r].exp_valid || !rows[r].trc) begin
            check($sformatf("row%0d.vector", r), vector_out, {N{rows[r].exp_lane}});
            check($sformatf("row%0d.chain", r), N*DW'(chainId_out), N*DW'(rows[r].exp_ch));
            check($sformatf("row%0d.flags", r), N*DW'({bof_out, eof_out}),
                  N*DW'({rows[r].exp_bof, rows[r].exp_eof}));
         end
      end

      // Lane overflow on the running-sum chain.
      beat(1'b1, 1'b0, 2'd1, 32'h7fff_ffff);
      expect_out("ovf.load", 1'b1, 32'h7fff_ffff, 2'd1, 1'b1, 1'b0);
      beat(1'b0, 1'b1, 2'd1, 32'd1);
`ifdef ACCUM_SATURATE_EN
      expect_out("ovf.add", 1'b1, 32'h7fff_ffff, 2'd1, 1'b0, 1'b1);
`else
      expect_out("ovf.add", 1'b1, 32'h8000_0000, 2'd1, 1'b0, 1'b1);
`endif

      // Reset in the middle of a chain-0 frame discards the partial sum.
      beat(1'b1, 1'b0, 2'd0, 32'd1);
      beat(1'b0, 1'b0, 2'd0, 32'd2);
      do_reset();
      cfg(8'd1, 8'd1); cfg(8'd1, 8'd2); cfg(8'd1, 8'd1); cfg(8'd1, 8'd0);
      beat(1'b0, 1'b1, 2'd0, 32'd4);
      expect_out("reset_mid.eof", 1'b1, 32'd4, 2'd0, 1'b1, 1'b1);

      // Randomized traffic with occasional config writes and one reset.
      for (int i = 0; i < 400; i++) begin
         vec_t       v;
         logic [7:0] cid, cd;
         for (int l = 0; l < N; l++)
            v[l] = ($urandom_range(0, 7) == 0) ? DW'($urandom) : DW'($urandom_range(0, 50));
         cid = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 8'd1 : 8'd3) : 8'd0;
         cd  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(3, 255)) : 8'($urandom_range(0, 2));
         if (i == 200) do_reset();
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
              2'($urandom_range(0, MC - 1)), v, cid, cd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
